// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : byte FIFO feeding a UART transmitter via tx_start/tx_busy
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              idle
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      GUARD_LAST = 2'd3;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        guard_q, guard_d;
  logic              overflow_q, overflow_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              pop;
  logic              wr_accept;

  // Flags come straight from the registered count, so wr_en never glitches them.
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign idle     = empty && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      guard_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        guard_d = '0;
      end
      S_WAIT_BUSY: begin
        // A transmitter that never acknowledges must not wedge the queue.
        if (tx_busy)                  state_d = S_WAIT_DONE;
        else if (guard_q == GUARD_LAST) state_d = S_IDLE;
        else                          guard_d = guard_q + 2'd1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_start_d = (state_d == S_LAUNCH);
    // A pop in the same cycle frees a slot, so a write while full still lands.
    wr_accept  = wr_en && (!full || pop);
    overflow_d = wr_en && !wr_accept;
    wr_ptr_d   = wr_accept ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : directed + random checks of uart_tx_fifo against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              idle;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_q [$];
  int         occ = 0;
  int         tick_n = 0;
  int         start_cnt = 0;
  int         start_ticks [$];
  logic       prev_start = 1'b0;
  logic       have_prev = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       stall = 1'b0;
  logic       never_busy = 1'b0;
  logic       start_pending = 1'b0;
  int         busy_left = 0;
  int         busy_len = 10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // One clock: sample after the edge, advance the queue model, then drive the transmitter model.
  task automatic tick();
    logic       w, bb, popped, acc;
    logic [7:0] d, eb;
    int         ob;
    w = wr_en; d = wr_data; ob = occ; bb = tx_busy;
    @(posedge clk);
    #1;
    tick_n++;
    busy_seen = busy_seen | bb;
    popped = tx_start;
    if (popped) begin
      start_cnt++;
      start_ticks.push_back(tick_n);
      chk("start_needs_data", 32'(ob > 0), 1);
      chk("start_while_busy", 32'(bb), 0);
      chk("start_back_to_back", 32'(prev_start), 0);
      if (have_prev && !never_busy) chk("busy_between_starts", 32'(busy_seen), 1);
      have_prev = 1'b1;
      busy_seen = 1'b0;
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(eb));
        last_data = eb;
      end
    end else begin
      chk("tx_data_hold", 32'(tx_data), 32'(last_data));
    end
    acc = w && (ob < DEPTH || popped);
    if (acc) exp_q.push_back(d);
    occ = ob + (acc ? 1 : 0) - ((popped && ob > 0) ? 1 : 0);
    chk("count", 32'(count), 32'(occ));
    chk("full", 32'(full), 32'(occ == DEPTH));
    chk("empty", 32'(empty), 32'(occ == 0));
    chk("overflow", 32'(overflow), 32'(w && !acc));
    prev_start = popped;
    if (busy_left > 0) busy_left--;
    if (start_pending && !never_busy) busy_left = busy_len;
    start_pending = tx_start;
    tx_busy = stall || (busy_left > 0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || idle !== 1'b1 || tx_busy) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < limit), 1);
    chk("idle_after_drain", 32'(idle), 1);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_idle", 32'(idle), 1);
    rst_n = 1'b1;

    // Single byte: launch one cycle after the write is visible.
    tick();
    write_byte(8'hA5);
    tick();
    chk("latency_start", 32'(tx_start), 1);
    chk("busy_frame_idle", 32'(idle), 0);
    drain(60);

    // Burst of 16 with the transmitter stalled, then let it drain in order.
    stall = 1'b1; tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    chk("burst_full", 32'(full), 1);
    chk("burst_count", 32'(count), 16);
    base = start_cnt;
    stall = 1'b0; tx_busy = 1'b0;
    drain(400);
    chk("burst_pulses", 32'(start_cnt - base), 16);
    chk("burst_last", 32'(last_data), 32'h10);

    // Overflow while full and stalled.
    stall = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 254)));
    write_byte(8'hFF);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    tick();

    // Pop and write in the same cycle while full.
    stall = 1'b0; tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    chk("popwr_start", 32'(tx_start), 1);
    chk("popwr_count", 32'(count), 16);
    chk("popwr_no_ovf", 32'(overflow), 0);
    drain(400);
    chk("popwr_last", 32'(last_data), 32'hC3);

    // Transmitter that never acknowledges.
    never_busy = 1'b1;
    start_ticks.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    n = 0;
    while (start_ticks.size() < 2 && n < 40) begin tick(); n++; end
    chk("guard_no_deadlock", 32'(start_ticks.size() >= 2), 1);
    if (start_ticks.size() >= 2)
      chk("guard_gap", 32'((start_ticks[1] - start_ticks[0]) >= 5 && (start_ticks[1] - start_ticks[0]) <= 7), 1);
    drain(60);
    never_busy = 1'b0;
    have_prev = 1'b0;

    // Reset mid-burst with the transmitter busy.
    stall = 1'b1; tx_busy = 1'b1;
    for (int i = 0; i < 7; i++) write_byte(8'($urandom));
    chk("pre_reset_count", 32'(count), 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_empty", 32'(empty), 1);
    chk("async_rst_start", 32'(tx_start), 0);
    chk("async_rst_idle", 32'(idle), 1);
    exp_q.delete(); occ = 0; stall = 1'b0; tx_busy = 1'b0;
    busy_left = 0; start_pending = 1'b0; prev_start = 1'b0; have_prev = 1'b0;
    busy_seen = 1'b0; last_data = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = start_cnt;
    repeat (20) tick();
    chk("no_start_after_reset", 32'(start_cnt - base), 0);
    write_byte(8'h5A);
    drain(60);
    chk("post_reset_launch", 32'(start_cnt - base), 1);

    // Random traffic with stall windows to force full/overflow.
    for (int i = 0; i < 600; i++) begin
      stall = ((i % 64) >= 44);
      if (stall) tx_busy = 1'b1;
      busy_len = $urandom_range(1, 12);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0; stall = 1'b0;
    drain(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-buffering feeder placed directly upstream of the UART transmitter. Accepts bytes from the system side (command parser, debug logger) into a DEPTH-entry FIFO.
- Drains the FIFO one byte at a time through the transmitter's tx_start/tx_data/tx_busy handshake.
- Lets producers burst bytes without watching the serial line. Issues exactly one start per byte and never re-launches while a frame is in flight.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  push wr_data this cycle
- wr_data  in  8  byte to enqueue
- full  out  1  FIFO holds DEPTH bytes
- empty  out  1  FIFO holds 0 bytes
- count  out  ADDR_W+1  current occupancy 0..DEPTH
- overflow  out  1  one-cycle pulse: a write was dropped because FIFO full
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_data  out  8  byte presented to transmitter
- tx_busy  in  1  transmitter frame in progress
- idle  out  1  FIFO empty and FSM in S_IDLE (all bytes handed off and finished)

Behaviour:
- Reset (async, rst_n=0): pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, idle=1, FSM=S_IDLE. FIFO contents are not reset. Reset mid-frame discards all queued bytes; tx_start=0 immediately.
- All other logic is synchronous to posedge clk.
- Storage: DEPTH x 8 register array. wr_ptr/rd_ptr are ADDR_W bits and wrap modulo DEPTH. count is a separate ADDR_W+1 counter.
  - full = (count==DEPTH); empty = (count==0).
  - All three are registered-consistent (derived from count, no glitch path from wr_en).
- Write: wr_en=1 and full=0 -> mem[wr_ptr]<=wr_data, wr_ptr+1.
  - wr_en=1 and full=1 -> byte dropped, pointers unchanged, overflow=1 for the next cycle only.
- Pop: occurs only on the FSM transition S_IDLE->S_LAUNCH.
  - tx_data<=mem[rd_ptr], rd_ptr+1.
- count update per cycle: +1 (write only), -1 (pop only), unchanged (both or neither).
  - Simultaneous write and pop while full: pop frees the slot, so the write is accepted, count stays DEPTH, and there is no overflow.
  - Write into empty FIFO: the byte is not popped in the same cycle. The pop uses the registered empty.
- FSM states:
  - S_IDLE: if !empty && !tx_busy -> pop, go S_LAUNCH.
  - S_LAUNCH: tx_start=1 for exactly this cycle; go S_WAIT_BUSY.
  - S_WAIT_BUSY: wait for tx_busy=1 (transmitter raises it one cycle after accepting tx_start), then go S_WAIT_DONE. Guard: if tx_busy is still 0 after 4 cycles in this state, go S_IDLE; the byte is considered sent.
  - S_WAIT_DONE: wait for tx_busy=0, then go S_IDLE.
- tx_start is a registered output, high only while the FSM is in S_LAUNCH. It is never high on two consecutive cycles.
- tx_data is held stable from the pop until the next pop.
- idle = empty && FSM==S_IDLE.
- Latency: write at edge N into empty FIFO with tx_busy=0 -> empty=0 after N -> pop at N+1 -> tx_start high in cycle after N+1 (visible N+1..N+2).
- Back-to-back bytes: the next pop occurs 1 cycle after tx_busy falls. Minimum gap between tx_start pulses = frame length + 3 cycles.
- External tx_busy=1 observed in S_IDLE (transmitter already busy) blocks launch until it falls.

Test Plan:
- Reset then single write 8'hA5 with a transmitter model (tx_busy rises 1 cycle after tx_start, stays high 10 cycles) -> one tx_start pulse 2 cycles after write; tx_data=8'hA5; count 1->0; idle=1 after tx_busy falls.
- Burst write 8'h01..8'h10 (16 bytes) on consecutive cycles -> full=1 at count 16, no overflow. Exactly 16 tx_start pulses with tx_data 01..10 in order. Every pulse is separated by a tx_busy high period.
- With FIFO full and transmitter stalled (tx_busy held 1), write 8'hFF -> overflow high for exactly 1 cycle, count stays 16, 8'hFF never appears on tx_data.
- Full FIFO with pop and write in the same cycle -> count stays 16, no overflow, written byte is transmitted last.
- Transmitter model that never raises tx_busy -> FSM leaves S_WAIT_BUSY after 4 cycles. Next byte launches; no deadlock.
- Assert rst_n=0 mid-burst (count=7, tx_busy=1) -> count=0, empty=1, tx_start=0 immediately. After release, no tx_start until a new write.
